seg7_to_bin: RTL and testbench



---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_digit_dec.sv | 38 +++
 rtl/seg7_to_bin.sv | 139 +++++++++++++
 tb/tb_seg7_to_bin.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the forward and reverse converters.
// Codes are active-low, segment order [0:6], written exactly as the forward path emits them.
package seg7_pkg;

    localparam logic [0:6] SEG_ZERO  = 7'b100_0000;
    localparam logic [0:6] SEG_ONE   = 7'b111_1001;
    localparam logic [0:6] SEG_TWO   = 7'b010_0100;
    localparam logic [0:6] SEG_THREE = 7'b011_0000;
    localparam logic [0:6] SEG_FOUR  = 7'b001_1001;
    localparam logic [0:6] SEG_FIVE  = 7'b001_0010;
    localparam logic [0:6] SEG_SIX   = 7'b000_0010;
    localparam logic [0:6] SEG_SEVEN = 7'b111_1000;
    localparam logic [0:6] SEG_EIGHT = 7'b000_0000;
    localparam logic [0:6] SEG_NINE  = 7'b001_1000;
    localparam logic [0:6] SEG_BLANK = 7'b111_1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG2 = 2'd1,
        DIG1 = 2'd2,
        DIG0 = 2'd3
    } state_e;

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational decode of one active-low 7-segment code back to a BCD digit.
// Unrecognised codes raise bad and yield digit 0 so they add nothing to the sum.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [0:6] code,
    input  logic       allow_blank,
    output logic [3:0] digit,
    output logic       bad
);

    // Pattern match against the shared segment table.
    always_comb begin
        digit = 4'd0;
        bad   = 1'b0;
        case (code)
            SEG_ZERO:  digit = 4'd0;
            SEG_ONE:   digit = 4'd1;
            SEG_TWO:   digit = 4'd2;
            SEG_THREE: digit = 4'd3;
            SEG_FOUR:  digit = 4'd4;
            SEG_FIVE:  digit = 4'd5;
            SEG_SIX:   digit = 4'd6;
            SEG_SEVEN: digit = 4'd7;
            SEG_EIGHT: digit = 4'd8;
            SEG_NINE:  digit = 4'd9;
            SEG_BLANK: begin
                if (allow_blank) begin
                    bad = 1'b0;
                end else begin
                    bad = 1'b1;
                end
            end
            default:   bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_to_bin.sv
// Rebuilds a binary value from three captured 7-segment digits, hundreds first,
// using a shift-and-add multiply-by-10 accumulation under a start/busy/done handshake.
module seg7_to_bin
    import seg7_pkg::*;
#(
    parameter int W_OUT       = 10,
    parameter bit ALLOW_BLANK = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [0:6]       seg0,
    input  logic [0:6]       seg1,
    input  logic [0:6]       seg2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W_OUT-1:0] x
);

    state_e           state_q, state_d;
    logic [0:6]       code0_q, code0_d;
    logic [0:6]       code1_q, code1_d;
    logic [0:6]       code2_q, code2_d;
    logic [W_OUT-1:0] acc_q, acc_d;
    logic [W_OUT-1:0] x_q, x_d;
    logic             invalid_q, invalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [3:0]       d0_s, d1_s, d2_s;
    logic             bad0_s, bad1_s, bad2_s;
    logic [W_OUT-1:0] acc_next_s;
    logic             bad_all_s;

    function automatic logic [W_OUT-1:0] mul10_add(input logic [W_OUT-1:0] a,
                                                    input logic [3:0]       d);
        return (a << 3) + (a << 1) + {{(W_OUT-4){1'b0}}, d};
    endfunction

    // The ones digit is never allowed to be blank.
    seg7_digit_dec u_dec0 (.code(code0_q), .allow_blank(1'b0),        .digit(d0_s), .bad(bad0_s));
    seg7_digit_dec u_dec1 (.code(code1_q), .allow_blank(ALLOW_BLANK), .digit(d1_s), .bad(bad1_s));
    seg7_digit_dec u_dec2 (.code(code2_q), .allow_blank(ALLOW_BLANK), .digit(d2_s), .bad(bad2_s));

    // Next-state, datapath and output decode for the conversion sequence.
    always_comb begin
        state_d    = state_q;
        code0_d    = code0_q;
        code1_d    = code1_q;
        code2_d    = code2_q;
        acc_d      = acc_q;
        x_d        = x_q;
        invalid_d  = invalid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        acc_next_s = mul10_add(acc_q, d0_s);
        bad_all_s  = invalid_q | bad0_s;
        case (state_q)
            IDLE: begin
                if (start) begin
                    code0_d   = seg0;
                    code1_d   = seg1;
                    code2_d   = seg2;
                    acc_d     = {W_OUT{1'b0}};
                    invalid_d = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = DIG2;
                end else begin
                    state_d   = IDLE;
                end
            end
            DIG2: begin
                acc_d     = {{(W_OUT-4){1'b0}}, d2_s};
                invalid_d = invalid_q | bad2_s;
                state_d   = DIG1;
            end
            DIG1: begin
                acc_d     = mul10_add(acc_q, d1_s);
                invalid_d = invalid_q | bad1_s;
                state_d   = DIG0;
            end
            DIG0: begin
                acc_d     = acc_next_s;
                invalid_d = bad_all_s;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = IDLE;
                // A bad conversion keeps the last good value visible on x.
                if (bad_all_s) begin
                    err_d = 1'b1;
                end else begin
                    x_d   = acc_next_s;
                    err_d = 1'b0;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            code0_q   <= 7'b111_1111;
            code1_q   <= 7'b111_1111;
            code2_q   <= 7'b111_1111;
            acc_q     <= {W_OUT{1'b0}};
            x_q       <= {W_OUT{1'b0}};
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code0_q   <= code0_d;
            code1_q   <= code1_d;
            code2_q   <= code2_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign x    = x_q;

endmodule

// File: tb/tb_seg7_to_bin.sv
// Directed bench for seg7_to_bin: one instance with blanking allowed, one without.
module tb_seg7_to_bin;
    import seg7_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [0:6] seg0, seg1, seg2;
    logic       busy_a, done_a, err_a;
    logic       busy_b, done_b, err_b;
    logic [9:0] x_a, x_b;

    int n_cmp = 0;
    int n_mis = 0;

    seg7_to_bin #(.W_OUT(10), .ALLOW_BLANK(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .seg0(seg0), .seg1(seg1), .seg2(seg2),
        .busy(busy_a), .done(done_a), .err(err_a), .x(x_a));

    seg7_to_bin #(.W_OUT(10), .ALLOW_BLANK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .seg0(seg0), .seg1(seg1), .seg2(seg2),
        .busy(busy_b), .done(done_b), .err(err_b), .x(x_b));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Starts one conversion from a post-edge point and checks the whole handshake on dut_a.
    task automatic run_conv(input string tag, input logic [0:6] s2, input logic [0:6] s1,
                            input logic [0:6] s0, input logic [9:0] exp_x, input logic exp_err);
        seg2 = s2; seg1 = s1; seg0 = s0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seg0 = 7'b101_0101; seg1 = 7'b101_0101; seg2 = 7'b101_0101;
        check_eq({tag, " busy c0"}, busy_a, 1'b1);
        check_eq({tag, " done c0"}, done_a, 1'b0);
        check_eq({tag, " err clr"}, err_a, 1'b0);
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq({tag, " busy"}, busy_a, 1'b1);
            check_eq({tag, " done early"}, done_a, 1'b0);
        end
        @(posedge clk); #1;
        check_eq({tag, " busy end"}, busy_a, 1'b0);
        check_eq({tag, " done"}, done_a, 1'b1);
        check_eq({tag, " x"}, x_a, exp_x);
        check_eq({tag, " err"}, err_a, exp_err);
        @(posedge clk); #1;
        check_eq({tag, " done pulse"}, done_a, 1'b0);
        check_eq({tag, " x hold"}, x_a, exp_x);
        check_eq({tag, " err hold"}, err_a, exp_err);
    endtask

    initial begin : main
        int ndone;
        int first_i;
        int last_i;
        rst = 1'b1; start = 1'b0;
        seg0 = SEG_ZERO; seg1 = SEG_ZERO; seg2 = SEG_ZERO;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst x", x_a, 10'd0);
        check_eq("rst busy", busy_a, 1'b0);
        check_eq("rst done", done_a, 1'b0);
        check_eq("rst err", err_a, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_conv("127", SEG_ONE, SEG_TWO, SEG_SEVEN, 10'd127, 1'b0);
        run_conv("999", SEG_NINE, SEG_NINE, SEG_NINE, 10'h3E7, 1'b0);
        run_conv("000", SEG_ZERO, SEG_ZERO, SEG_ZERO, 10'd0, 1'b0);
        run_conv("005", SEG_ZERO, SEG_ZERO, SEG_FIVE, 10'd5, 1'b0);
        check_eq("005 b x", x_b, 10'd5);
        run_conv("blank5", SEG_BLANK, SEG_BLANK, SEG_FIVE, 10'd5, 1'b0);
        check_eq("blank5 b err", err_b, 1'b1);
        check_eq("blank5 b x", x_b, 10'd5);
        run_conv("blank0", SEG_ONE, SEG_TWO, SEG_BLANK, 10'd5, 1'b1);
        run_conv("042", SEG_ZERO, SEG_FOUR, SEG_TWO, 10'd42, 1'b0);
        run_conv("bad1", SEG_ZERO, 7'b101_0101, SEG_ZERO, 10'd42, 1'b1);
        run_conv("300", SEG_THREE, SEG_ZERO, SEG_ZERO, 10'd300, 1'b0);
        run_conv("all8", SEG_EIGHT, SEG_SIX, SEG_EIGHT, 10'd868, 1'b0);

        // Extra start pulses while busy must be dropped.
        seg2 = SEG_ONE; seg1 = SEG_FIVE; seg0 = SEG_SIX; start = 1'b1;
        ndone = 0;
        @(posedge clk); #1;
        seg0 = SEG_NINE;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 2) start = 1'b0;
            if (done_a) ndone++;
        end
        check_eq("ign done cnt", ndone, 1);
        check_eq("ign x", x_a, 10'd156);

        // Continuous start gives a done every 4 cycles.
        seg2 = SEG_ONE; seg1 = SEG_TWO; seg0 = SEG_THREE; start = 1'b1;
        ndone = 0; first_i = -1; last_i = -1;
        @(posedge clk); #1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done_a) begin
                ndone++;
                if (first_i < 0) first_i = i;
                last_i = i;
            end
        end
        start = 1'b0;
        check_eq("b2b done cnt", ndone, 3);
        check_eq("b2b first", first_i, 3);
        check_eq("b2b last", last_i, 11);
        check_eq("b2b busy", busy_a, 1'b1);
        check_eq("b2b x", x_a, 10'd123);
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset in DIG1 aborts with no done.
        seg2 = SEG_NINE; seg1 = SEG_EIGHT; seg0 = SEG_SEVEN; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("arst x", x_a, 10'd0);
        check_eq("arst busy", busy_a, 1'b0);
        check_eq("arst done", done_a, 1'b0);
        check_eq("arst err", err_a, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done_a || busy_a) ndone++;
        end
        check_eq("arst quiet", ndone, 0);
        run_conv("post rst", SEG_ZERO, SEG_FOUR, SEG_TWO, 10'd42, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
